// File: rtl/reg_share_arbiter.sv
// Round-robin shared register: grants one requester, loads its data into q, then holds q.
// Latency: req seen in IDLE -> gnt next cycle -> q/wr_pulse the cycle after; req ignored while busy.
module reg_share_arbiter #(
  parameter int NREQ        = 4,
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 2,
  localparam int OW = (NREQ > 2) ? $clog2(NREQ) : 1,
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      q,
  output logic [OW-1:0]         q_owner,
  output logic                  wr_pulse,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, HOLD = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [OW-1:0]     sel_q, sel_d;
  logic [OW-1:0]     ptr_q, ptr_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic [OW-1:0]     q_owner_q, q_owner_d;
  logic              wr_pulse_q, wr_pulse_d;
  logic              busy_q, busy_d;

  logic              found;
  logic [OW-1:0]     winner;

  // First pending requester at or after ptr, wrapping; the last winner sits at the tail.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = OW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sel_q      <= '0;
      ptr_q      <= '0;
      gnt_q      <= '0;
      q_q        <= '0;
      q_owner_q  <= '0;
      wr_pulse_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      q_q        <= q_d;
      q_owner_q  <= q_owner_d;
      wr_pulse_q <= wr_pulse_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = WRITE;
          sel_d   = winner;
        end
      end
      WRITE: begin
        ptr_d = (sel_q == OW'(NREQ - 1)) ? '0 : sel_q + 1'b1;
        if (HOLD_CYCLES > 0) begin
          state_d = HOLD;
          cnt_d   = CW'(HOLD_CYCLES);
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CW'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d      = '0;
    q_d        = q_q;
    q_owner_d  = q_owner_q;
    wr_pulse_d = 1'b0;
    busy_d     = (state_d != IDLE);
    if (state_q == IDLE && found) gnt_d = {{(NREQ-1){1'b0}}, 1'b1} << winner;
    // The write completes regardless of req during the grant cycle.
    if (state_q == WRITE) begin
      q_d        = wdata[sel_q*WIDTH +: WIDTH];
      q_owner_d  = sel_q;
      wr_pulse_d = 1'b1;
    end
  end

  assign gnt      = gnt_q;
  assign q        = q_q;
  assign q_owner  = q_owner_q;
  assign wr_pulse = wr_pulse_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Bench for reg_share_arbiter: two instances (hold 2 and hold 0) on shared stimulus,
// compared each cycle against a schedule-based reference model plus directed scenarios.
module tb_reg_share_arbiter;
  localparam int N = 4, W = 8, OW = 2, MAXC = 1024;

  logic clk, reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   gnt_a, gnt_b;
  logic [W-1:0]   q_a, q_b;
  logic [OW-1:0]  own_a, own_b;
  logic           wr_a, wr_b, busy_a, busy_b;

  reg_share_arbiter #(.NREQ(N), .WIDTH(W), .HOLD_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset), .req(req), .wdata(wdata),
    .gnt(gnt_a), .q(q_a), .q_owner(own_a), .wr_pulse(wr_a), .busy(busy_a));

  reg_share_arbiter #(.NREQ(N), .WIDTH(W), .HOLD_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .req(req), .wdata(wdata),
    .gnt(gnt_b), .q(q_b), .q_owner(own_b), .wr_pulse(wr_b), .busy(busy_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = -1;

  // Model: per instance, expected grants/busy/writes scheduled by absolute cycle number.
  int           hold_len [2] = '{2, 0};
  int           gsel     [2][MAXC];
  bit           busy_at  [2][MAXC];
  bit           wr_at    [2][MAXC];
  logic [W-1:0] wr_val   [2][MAXC];
  int           wr_own   [2][MAXC];
  int           ptr      [2];
  int           free_at  [2];
  logic [W-1:0] mq       [2];
  int           mown     [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic observe(input int i, output logic [N-1:0] g, output logic [W-1:0] qq,
                         output int ow, output logic wr, output logic bz);
    if (i == 0) begin g = gnt_a; qq = q_a; ow = int'(own_a); wr = wr_a; bz = busy_a; end
    else        begin g = gnt_b; qq = q_b; ow = int'(own_b); wr = wr_b; bz = busy_b; end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt_a"}, 32'(gnt_a), 0);  chk({tag, "_q_a"}, 32'(q_a), 0);
    chk({tag, "_busy_a"}, 32'(busy_a), 0); chk({tag, "_wr_a"}, 32'(wr_a), 0);
    chk({tag, "_gnt_b"}, 32'(gnt_b), 0);  chk({tag, "_q_b"}, 32'(q_b), 0);
    chk({tag, "_busy_b"}, 32'(busy_b), 0); chk({tag, "_wr_b"}, 32'(wr_b), 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int c = cyc; c < cyc + 8; c++) begin
        gsel[i][c] = -1; busy_at[i][c] = 0; wr_at[i][c] = 0;
      end
      ptr[i] = 0; free_at[i] = cyc; mq[i] = '0; mown[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    logic [N-1:0] g; logic [W-1:0] qq; int ow; logic wr, bz;
    int k, w, s;
    bit hit;
    k = cyc;
    s = gsel[i][k];
    // wdata is taken at the end of the grant cycle
    if (s >= 0) begin
      wr_at[i][k+1] = 1; wr_val[i][k+1] = wdata[s*W +: W]; wr_own[i][k+1] = s;
    end
    if (wr_at[i][k]) begin mq[i] = wr_val[i][k]; mown[i] = wr_own[i][k]; end
    observe(i, g, qq, ow, wr, bz);
    chk($sformatf("m%0d_gnt", i), 32'(g), (s >= 0) ? (32'd1 << s) : 32'd0);
    chk($sformatf("m%0d_busy", i), 32'(bz), 32'(busy_at[i][k]));
    chk($sformatf("m%0d_wr", i), 32'(wr), 32'(wr_at[i][k]));
    chk($sformatf("m%0d_q", i), 32'(qq), 32'(mq[i]));
    chk($sformatf("m%0d_own", i), 32'(ow), 32'(mown[i]));
    if (k >= free_at[i] && req != 0) begin
      hit = 0; w = 0;
      for (int d = 0; d < N; d++) begin
        if (!hit && req[(ptr[i] + d) % N]) begin hit = 1; w = (ptr[i] + d) % N; end
      end
      gsel[i][k+1] = w;
      for (int d = 1; d <= 1 + hold_len[i]; d++) busy_at[i][k+d] = 1;
      free_at[i] = k + 2 + hold_len[i];
      ptr[i] = (w + 1) % N;
    end
  endtask

  task automatic step(input logic [N-1:0] r, input logic [N*W-1:0] wd, input bit do_rst);
    @(posedge clk);
    cyc++;
    #1 req = r; wdata = wd;
    if (do_rst) begin
      #1 reset = 1'b1;
      #1 chk_zero("midrst");
      #1 reset = 1'b0;
      model_reset();
    end
    @(negedge clk);
    model_step(0);
    model_step(1);
  endtask

  logic [N*W-1:0] wd;
  int gq[$];
  int qv[$];
  int cnt;

  initial begin
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < MAXC; c++) begin
        gsel[i][c] = -1; busy_at[i][c] = 0; wr_at[i][c] = 0; wr_val[i][c] = '0; wr_own[i][c] = 0;
      end
    for (int i = 0; i < 2; i++) begin ptr[i] = 0; free_at[i] = 0; mq[i] = '0; mown[i] = 0; end
    reset = 1'b0; req = '0; wdata = '0;
    #1 reset = 1'b1;
    #1 chk_zero("por");
    #1 reset = 1'b0;

    step('0, '0, 0);
    step('0, '0, 0);

    // Single write on the hold-2 instance, then reset inside its hold window.
    wd = '0; wd[23:16] = 8'hA5;
    step(4'b0100, wd, 0);
    step(4'b0100, wd, 0);
    chk("single_gnt", 32'(gnt_a), 32'b0100);
    chk("single_busy", 32'(busy_a), 1);
    step('0, wd, 0);
    chk("single_q", 32'(q_a), 32'hA5);
    chk("single_own", 32'(own_a), 2);
    chk("single_wr", 32'(wr_a), 1);
    step('0, wd, 1);

    // Continuous requests, zero hold: strict rotation every two cycles.
    wd = {8'd4, 8'd3, 8'd2, 8'd1};
    for (int t = 0; t < 10; t++) begin
      step(4'b1111, wd, 0);
      if (gnt_b != 0) gq.push_back(int'(gnt_b));
      if (wr_b) qv.push_back(int'(q_b));
    end
    chk("rr_count", 32'(gq.size() >= 5 && qv.size() >= 4), 1);
    if (gq.size() >= 5) begin
      chk("rr_g0", gq[0], 1); chk("rr_g1", gq[1], 2); chk("rr_g2", gq[2], 4);
      chk("rr_g3", gq[3], 8); chk("rr_g4", gq[4], 1);
    end
    if (qv.size() >= 4) begin
      chk("rr_q0", qv[0], 1); chk("rr_q1", qv[1], 2); chk("rr_q2", qv[2], 3); chk("rr_q3", qv[3], 4);
    end

    // Wrap: after requester 2 wins, only 0 and 1 request.
    step('0, wd, 1);
    step(4'b0100, wd, 0);
    step(4'b0011, wd, 0);
    gq.delete();
    for (int t = 0; t < 6; t++) begin
      step(4'b0011, wd, 0);
      if (gnt_b != 0) gq.push_back(int'(gnt_b));
    end
    chk("wrap_count", 32'(gq.size() >= 2), 1);
    if (gq.size() >= 2) begin chk("wrap_g0", gq[0], 1); chk("wrap_g1", gq[1], 2); end
    cnt = 0;
    foreach (gq[j]) if (gq[j] == 8) cnt++;
    chk("wrap_no3", cnt, 0);

    // Withdraw during the grant cycle: write still lands, no repeat grant.
    step('0, wd, 1);
    wd = '0; wd[15:8] = 8'h3C;
    step(4'b0010, wd, 0);
    step(4'b0000, wd, 0);
    chk("wd_gnt", 32'(gnt_b), 32'b0010);
    step('0, wd, 0);
    chk("wd_q", 32'(q_b), 32'h3C);
    chk("wd_wr", 32'(wr_b), 1);
    cnt = 0;
    for (int t = 0; t < 4; t++) begin
      step('0, wd, 0);
      if (gnt_a != 0 || gnt_b != 0) cnt++;
    end
    chk("wd_nogrant", cnt, 0);

    // Reset mid-hold after requester 3 wins restores requester 0 priority.
    step('0, wd, 1);
    step(4'b1000, wd, 0);
    step('0, wd, 0);
    step('0, wd, 0);
    chk("r6_busy", 32'(busy_a), 1);
    step(4'b1001, wd, 1);
    step(4'b1001, wd, 0);
    chk("r6_gnt_a", 32'(gnt_a), 32'b0001);
    chk("r6_gnt_b", 32'(gnt_b), 32'b0001);

    // Random traffic with occasional resets.
    for (int t = 0; t < 500; t++) begin
      logic [N-1:0] r;
      r  = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      wd = N*W'($urandom);
      step(r, wd, $urandom_range(0, 59) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
